// File: rtl/localisation_pkg.sv
// Shared definitions for the trilateration localisation datapath:
// width helpers and the point-in-range checker state encoding.
package localisation_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    SQR,
    DONE
  } state_t;

  // Width of a coordinate difference for N-bit jammer coordinates.
  function automatic int diff_width(input int n);
    return n + 3;
  endfunction

  // Width of a squared distance (sum of two squared differences).
  function automatic int dist_width(input int n);
    return 2 * n + 7;
  endfunction

endpackage

// File: rtl/inside_multi_dp.sv
// Time-shared datapath: operand mux, subtractor, one squarer, distance
// accumulator and the range comparator for the slot currently selected.
module inside_multi_dp
  import localisation_pkg::*;
#(
  parameter int N      = 8,
  parameter int STRICT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  state_t              state,
  input  logic                clear,
  input  logic signed [N+1:0] xp,
  input  logic signed [N+1:0] yp,
  input  logic signed [N-1:0] xj,
  input  logic signed [N-1:0] yj,
  input  logic signed [N:0]   rj,
  output logic                hit
);

  localparam int DW = diff_width(N);
  localparam int HW = dist_width(N);

  logic signed [DW-1:0]   sub_a;
  logic signed [DW-1:0]   sub_b;
  logic signed [DW-1:0]   diff;
  logic signed [2*DW-1:0] prod;
  logic [HW-1:0]          sq;
  logic [HW-1:0]          acc_reg;

  // In SQR the radius goes through the same squarer with a zero subtrahend.
  always_comb begin
    sub_a = DW'(xp);
    sub_b = DW'(xj);
    case (state)
      SQY: begin
        sub_a = DW'(yp);
        sub_b = DW'(yj);
      end
      SQR: begin
        sub_a = DW'(rj);
        sub_b = '0;
      end
      default: ;
    endcase
  end

  assign diff = sub_a - sub_b;
  assign prod = diff * diff;
  assign sq   = HW'($unsigned(prod));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg <= '0;
    end else begin
      case (state)
        SQX:     acc_reg <= sq;
        SQY:     acc_reg <= acc_reg + sq;
        default: ;
      endcase
    end
  end

  // A negative radius marks an unused slot and never reports a hit.
  assign hit = !rj[N] && ((STRICT != 0) ? (acc_reg < sq) : (acc_reg <= sq));

endmodule

// File: rtl/inside_multi.sv
// Sequential point-in-range checker: walks K jammer circles through a shared
// squarer and reports a hit mask, hit count and any-hit flag per request.
module inside_multi
  import localisation_pkg::*;
#(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int STRICT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [N+1:0]      xP,
  input  logic signed [N+1:0]      yP,
  input  logic [K*N-1:0]           xJ,
  input  logic [K*N-1:0]           yJ,
  input  logic [K*(N+1)-1:0]       rJ,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [K-1:0]             in_mask,
  output logic [$clog2(K+1)-1:0]   in_count,
  output logic                     in_any
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(K + 1);

  state_t               state_reg;
  state_t               state_next;
  logic [KW-1:0]        k_reg;
  logic [K-1:0]         mask_reg;
  logic signed [N+1:0]  xp_reg;
  logic signed [N+1:0]  yp_reg;
  logic [K*N-1:0]       xj_reg;
  logic [K*N-1:0]       yj_reg;
  logic [K*(N+1)-1:0]   rj_reg;
  logic                 accept;
  logic                 last_slot;
  logic                 hit;
  logic [CW-1:0]        count_next;

  logic signed [N-1:0]  xj_slot [K];
  logic signed [N-1:0]  yj_slot [K];
  logic signed [N:0]    rj_slot [K];

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      assign xj_slot[gi] = xj_reg[gi*N +: N];
      assign yj_slot[gi] = yj_reg[gi*N +: N];
      assign rj_slot[gi] = rj_reg[gi*(N+1) +: N+1];
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_slot = (k_reg == KW'(K - 1));
  assign out_valid = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SQX;
      SQX:     state_next = SQY;
      SQY:     state_next = SQR;
      SQR:     state_next = last_slot ? DONE : SQX;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        k_reg    <= '0;
        mask_reg <= '0;
      end else if (state_reg == SQR) begin
        mask_reg[k_reg] <= hit;
        if (!last_slot) k_reg <= k_reg + KW'(1);
      end
    end
  end

  // Request operands only need capturing; their contents never gate control.
  always_ff @(posedge clk) begin
    if (accept) begin
      xp_reg <= xP;
      yp_reg <= yP;
      xj_reg <= xJ;
      yj_reg <= yJ;
      rj_reg <= rJ;
    end
  end

  inside_multi_dp #(
    .N      (N),
    .STRICT (STRICT)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .state (state_reg),
    .clear (accept),
    .xp    (xp_reg),
    .yp    (yp_reg),
    .xj    (xj_slot[k_reg]),
    .yj    (yj_slot[k_reg]),
    .rj    (rj_slot[k_reg]),
    .hit   (hit)
  );

  always_comb begin
    count_next = '0;
    for (int i = 0; i < K; i++) begin
      count_next = count_next + CW'(mask_reg[i]);
    end
  end

  assign in_mask  = mask_reg;
  assign in_count = count_next;
  assign in_any   = |mask_reg;

endmodule

// File: tb/tb_inside_multi.sv
// Scoreboard bench for inside_multi: inclusive and strict instances share one
// stimulus stream; expected masks come from an integer distance model.
module tb_inside_multi;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int CW = $clog2(K + 1);
  localparam int PW = N + 2;
  localparam int RW = N + 1;
  localparam int RT = 2 * K + CW + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic signed [N+1:0] xp_bus = '0;
  logic signed [N+1:0] yp_bus = '0;
  logic [K*N-1:0]      xj_bus = '0;
  logic [K*N-1:0]      yj_bus = '0;
  logic [K*RW-1:0]     rj_bus = '0;

  logic          in_ready0, out_valid0, in_any0;
  logic [K-1:0]  in_mask0;
  logic [CW-1:0] in_count0;
  logic          in_ready1, out_valid1, in_any1;
  logic [K-1:0]  in_mask1;
  logic [CW-1:0] in_count1;

  int st_xp, st_yp;
  int st_xj[K];
  int st_yj[K];
  int st_rj[K];

  logic [K-1:0] exp0_q[$];
  logic [K-1:0] exp1_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inside_multi #(.N(N), .K(K), .STRICT(0)) u_incl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .xP(xp_bus), .yP(yp_bus), .xJ(xj_bus), .yJ(yj_bus), .rJ(rj_bus),
    .out_valid(out_valid0), .out_ready(out_ready),
    .in_mask(in_mask0), .in_count(in_count0), .in_any(in_any0)
  );

  inside_multi #(.N(N), .K(K), .STRICT(1)) u_strict (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .xP(xp_bus), .yP(yp_bus), .xJ(xj_bus), .yJ(yj_bus), .rJ(rj_bus),
    .out_valid(out_valid1), .out_ready(out_ready),
    .in_mask(in_mask1), .in_count(in_count1), .in_any(in_any1)
  );

  function automatic logic [K-1:0] model(input bit strict);
    logic [K-1:0] m;
    longint dx, dy, h, r2;
    m = '0;
    for (int k = 0; k < K; k++) begin
      dx = longint'(st_xp - st_xj[k]);
      dy = longint'(st_yp - st_yj[k]);
      h  = dx * dx + dy * dy;
      r2 = longint'(st_rj[k]) * longint'(st_rj[k]);
      if (st_rj[k] >= 0) m[k] = strict ? (h < r2) : (h <= r2);
    end
    return m;
  endfunction

  task automatic set_unused();
    for (int k = 0; k < K; k++) begin
      st_xj[k] = 0;
      st_yj[k] = 0;
      st_rj[k] = -1;
    end
  endtask

  task automatic drive_inputs();
    xp_bus = PW'(st_xp);
    yp_bus = PW'(st_yp);
    for (int k = 0; k < K; k++) begin
      xj_bus[k*N +: N]   = N'(st_xj[k]);
      yj_bus[k*N +: N]   = N'(st_yj[k]);
      rj_bus[k*RW +: RW] = RW'(st_rj[k]);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after acceptance.
  task automatic send();
    drive_inputs();
    exp0_q.push_back(model(1'b0));
    exp1_q.push_back(model(1'b1));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output logic [RT-1:0] got,
                         output logic [RT-1:0] exp);
    logic [K-1:0] e0, e1;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid0) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    got = {in_mask0, in_count0, in_any0, in_mask1};
    e0 = 'x;
    e1 = 'x;
    if (exp0_q.size() > 0) e0 = exp0_q.pop_front();
    if (exp1_q.size() > 0) e1 = exp1_q.pop_front();
    exp = {e0, CW'($countones(e0)), |e0, e1};
    $display("txn mask=%b count=%0d any=%b strict_mask=%b lat=%0d",
             in_mask0, in_count0, in_any0, in_mask1, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready0);
    end
    n_checks++;
    if ({out_valid0, in_mask0, in_count0, in_any0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b mask=%b count=%0d any=%b expected all 0",
               out_valid0, in_mask0, in_count0, in_any0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready0);
    end
  endtask

  task automatic run_one(input string name);
    int lat;
    logic [RT-1:0] got, exp;
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready: got %b expected 1", name, in_ready0);
    end
    send();
    collect(lat, got, exp);
    n_checks++;
    if (lat !== 12) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected 12", name, lat);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s_result: got %h expected %h", name, got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    set_unused();
    st_xp = 0; st_yp = 0;
    st_xj[0] = 3; st_yj[0] = 4; st_rj[0] = 5;
    run_one("boundary");
  endtask

  task automatic test_extremes();
    set_unused();
    st_xp = -512; st_yp = -512;
    st_xj[0] = 127; st_yj[0] = 127; st_rj[0] = 255;
    run_one("extreme_far");
    set_unused();
    st_xp = 127; st_yp = 127;
    st_xj[1] = 127; st_yj[1] = 127; st_rj[1] = 0;
    st_xj[0] = -128; st_yj[0] = -128; st_rj[0] = -256;
    run_one("extreme_zero_radius");
    set_unused();
    st_xp = 511; st_yp = 511;
    st_xj[3] = -128; st_yj[3] = -128; st_rj[3] = 255;
    run_one("extreme_pos");
  endtask

  task automatic test_unused();
    set_unused();
    st_xp = 10; st_yp = -20;
    st_xj[2] = 10; st_yj[2] = -20;
    run_one("unused_slot");
    st_xp = 5; st_yp = 5;
    for (int k = 0; k < K; k++) begin
      st_xj[k] = k * 3; st_yj[k] = 6 - k; st_rj[k] = 10 + k;
    end
    run_one("all_valid");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [RT-1:0] got, exp, now_v;
    set_unused();
    st_xp = 0; st_yp = 0;
    st_xj[1] = 1; st_yj[1] = 1; st_rj[1] = 2;
    st_xj[3] = 50; st_yj[3] = 0; st_rj[3] = 50;
    out_ready = 1'b0;
    send();
    collect(lat, got, exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL bp_result: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      xp_bus = PW'(i * 17 - 40);
      rj_bus = ~rj_bus;
      @(negedge clk);
      now_v = {in_mask0, in_count0, in_any0, in_mask1};
      n_checks++;
      if ({out_valid0, in_ready0} !== 2'b10 || now_v !== got) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b ready=%b res=%h expected valid=1 ready=0 res=%h",
                 out_valid0, in_ready0, now_v, got);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0",
               in_ready0, out_valid0);
    end
    n_checks++;
    if (exp0_q.size() != 0) begin
      n_fail++; $display("FAIL bp_queue: got %0d pending expected 0", exp0_q.size());
    end
  endtask

  task automatic test_reset_mid();
    set_unused();
    st_xp = 2; st_yp = 2;
    for (int k = 0; k < K; k++) begin
      st_xj[k] = 0; st_yj[k] = 0; st_rj[k] = 5;
    end
    send();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp0_q.delete();
    exp1_q.delete();
    n_checks++;
    if ({out_valid0, in_ready0, in_mask0, in_any0} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got valid=%b ready=%b mask=%b any=%b expected all 0",
               out_valid0, in_ready0, in_mask0, in_any0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got ready=%b valid=%b expected ready=1 valid=0",
               in_ready0, out_valid0);
    end
    st_rj[2] = 1;
    st_xj[0] = 7; st_yj[0] = 7; st_rj[0] = 7;
    run_one("after_reset");
  endtask

  task automatic test_back_to_back();
    int lat, last_cyc;
    logic [RT-1:0] got, exp;
    last_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      st_xp = 20 * i - 20; st_yp = 3 - i;
      for (int k = 0; k < K; k++) begin
        st_xj[k] = 15 * k - 25; st_yj[k] = k - i; st_rj[k] = 12 + 4 * i;
      end
      drive_inputs();
      exp0_q.push_back(model(1'b0));
      exp1_q.push_back(model(1'b1));
      in_valid = 1'b1;
      if (i > 0) @(negedge clk);
      collect(lat, got, exp);
      if (i == 2) in_valid = 1'b0;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", i, got, exp);
      end
      if (i > 0) begin
        n_checks++;
        if (cyc - last_cyc != 14) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got %0d expected 14", i, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      st_xp = int'($urandom_range(200)) - 100;
      st_yp = int'($urandom_range(200)) - 100;
      for (int k = 0; k < K; k++) begin
        st_xj[k] = int'($urandom_range(200)) - 100;
        st_yj[k] = int'($urandom_range(200)) - 100;
        st_rj[k] = int'($urandom_range(220)) - 20;
      end
      run_one("random");
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_extremes();
    test_unused();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
